// File: rtl/req_age_queue.sv
// req_age_queue: in-order request queue with timestamp admission and age-based release.
// Requests are admitted once cur_time reaches their trace timestamp, held in arrival
// order, aged once per cycle, and released from the head via valid/ready after
// reaching AGE_LIMIT. Out-of-order timestamps are consumed and flagged, not stored.
//   CPU_clock, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready, in_*     : request input handshake and payload
//   out_valid/out_ready, out_*  : head entry output handshake and payload
//   cur_time                    : simulation time counter
//   count, full, empty          : occupancy status
//   insert_flag, exit_flag      : registered one-cycle event pulses
//   order_err                   : registered pulse for a discarded out-of-order request
module req_age_queue #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 33,
  parameter int TIME_W    = 64,
  parameter int AGE_LIMIT = 100,
  parameter int AGE_W     = 8
) (
  input  logic                         CPU_clock,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TIME_W-1:0]            in_time,
  input  logic [1:0]                   in_opcode,
  input  logic [ADDR_W-1:0]            in_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TIME_W-1:0]            out_time,
  output logic [1:0]                   out_opcode,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [TIME_W-1:0]            cur_time,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         insert_flag,
  output logic                         exit_flag,
  output logic                         order_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [TIME_W-1:0] slot_time [DEPTH];
  logic [1:0]        slot_op   [DEPTH];
  logic [ADDR_W-1:0] slot_addr [DEPTH];
  logic [AGE_W-1:0]  slot_age  [DEPTH];

  logic [TIME_W-1:0] last_time;
  logic              insert_p1;
  logic              exit_p1;
  logic              err_p1;

  logic              hs;
  logic              ord_bad;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  wr_idx;

  function automatic logic [AGE_W-1:0] sat_age(input logic [AGE_W-1:0] a);
    if (a >= AGE_MAX) return AGE_MAX;
    return a + 1'b1;
  endfunction

  // Stage p0: combinational handshake decode
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && (in_time <= cur_time);
  assign hs        = in_valid && in_ready;
  assign ord_bad   = hs && (in_time < last_time);
  assign push      = hs && !ord_bad;
  assign out_valid = !empty && (slot_age[0] == AGE_MAX);
  assign pop       = out_valid && out_ready;
  assign wr_idx    = pop ? (count - 1'b1) : count;

  assign out_time   = empty ? '0 : slot_time[0];
  assign out_opcode = empty ? '0 : slot_op[0];
  assign out_addr   = empty ? '0 : slot_addr[0];

  assign insert_flag = insert_p1;
  assign exit_flag   = exit_p1;
  assign order_err   = err_p1;

  // Stage p1: control state, ages and event flags
  always_ff @(posedge CPU_clock or posedge rst) begin
    if (rst) begin
      count     <= '0;
      cur_time  <= '0;
      last_time <= '0;
      insert_p1 <= 1'b0;
      exit_p1   <= 1'b0;
      err_p1    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_age[i] <= '0;
      end
    end else begin
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      insert_p1 <= push;
      exit_p1   <= pop;
      err_p1    <= ord_bad;
      if (empty && in_valid && (in_time > cur_time)) begin
        cur_time <= in_time;
      end else begin
        cur_time <= cur_time + 1'b1;
      end
      if (push) begin
        last_time <= in_time;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CNT_W'(i))) begin
          slot_age[i] <= '0;
        end else if (pop) begin
          if ((i < DEPTH-1) && (CNT_W'(i+1) < count)) begin
            slot_age[i] <= sat_age(slot_age[(i < DEPTH-1) ? i+1 : i]);
          end else begin
            slot_age[i] <= '0;
          end
        end else if (CNT_W'(i) < count) begin
          slot_age[i] <= sat_age(slot_age[i]);
        end else begin
          slot_age[i] <= '0;
        end
      end
    end
  end

  // Stage p1: payload storage (only meaningful within 0..count-1)
  always_ff @(posedge CPU_clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CNT_W'(i))) begin
        slot_time[i] <= in_time;
        slot_op[i]   <= in_opcode;
        slot_addr[i] <= in_addr;
      end else if (pop && (i < DEPTH-1)) begin
        slot_time[i] <= slot_time[(i < DEPTH-1) ? i+1 : i];
        slot_op[i]   <= slot_op[(i < DEPTH-1) ? i+1 : i];
        slot_addr[i] <= slot_addr[(i < DEPTH-1) ? i+1 : i];
      end
    end
  end

endmodule
